int_gen: RTL and testbench
==========================

# int_gen

Programmable external-interrupt source that drives the CPU top's `interrupt` input and responds to the interrupt-acknowledge write the CPU issues on `m_int_addr`/`m_int_byteen`. Sits in the testbench/SoC shell, outside the CPU top, and forms the device end of the interrupt handshake. It raises a periodic level interrupt, holds it until acknowledged, and queues events that expire while an interrupt is outstanding. It also counts acknowledges and spurious writes so that exception-handler behaviour can be scored.

## Interface

- `PERIOD`, 100, cycles between timer events; must be ≥ 2.
- `ACK_ADDR`, 32'h0000_7F20, byte address whose write acknowledges the interrupt.
- `GAP_CYCLES`, 2, minimum cycles `interrupt` stays low between two queued assertions; must be ≥ 1.
- `TRIGGER_PC`, 32'h0000_3010, PC match address; used only under the configuration macro.

Ports:

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `gen_en` input 1: generator enable.
- `m_int_addr` input 32: acknowledge-write address from the CPU top.
- `m_int_byteen` input 4: acknowledge-write byte enables; nonzero means a write this cycle.
- `macroscopic_pc` input 32: CPU macroscopic PC; ignored unless the macro is defined.
- `interrupt` output 1: level interrupt to the CPU top, registered.
- `pending` output 4: queued, not-yet-asserted events.
- `ack_count` output 16: valid acknowledges, wrapping.
- `spurious_count` output 8: acknowledge writes received outside ASSERT, saturating at 255.

## Operation

- An ack write is `m_int_byteen != 0` && `m_int_addr[31:2] == ACK_ADDR[31:2]`.
- The down-counter `cnt` reloads to `PERIOD-1`. It decrements every cycle in COUNT, ASSERT and GAP. A timer event occurs in a cycle where `cnt == 0`; `cnt` reloads in that same cycle, so the counter is free-running.
- State IDLE:
  - `interrupt` = 0, `cnt` held at `PERIOD-1`, `pending` cleared.
  - `gen_en` = 1 moves to COUNT.
- State COUNT:
  - A timer event moves to ASSERT.
- State ASSERT:
  - `interrupt` = 1.
  - A timer event increments `pending`, saturating at 15.
  - An ack increments `ack_count` and leaves ASSERT. The next state is GAP if `pending` (after any same-cycle increment) is > 0, otherwise COUNT.
- State GAP:
  - `interrupt` = 0.
  - A timer event increments `pending`.
  - After `GAP_CYCLES` cycles, move to ASSERT and decrement `pending`. An event in that same exit cycle nets zero change.
- An ack in IDLE, COUNT or GAP increments `spurious_count` and has no other effect.
- `gen_en` = 0 in any state returns to IDLE on the next edge. That IDLE entry clears `pending` and drops `interrupt`, and counters are retained.

## Timing

- Reset values: `interrupt` = 0, `pending` = 0, `ack_count` = 0, `spurious_count` = 0, state IDLE, `cnt` = `PERIOD-1`.
- Reset takes effect immediately, including mid-assertion; `interrupt` falls without waiting for a clock edge.
- `interrupt` rises on the edge exactly `PERIOD` cycles after the first edge in COUNT.
- Ack latency:
  - `interrupt` falls on the edge that samples the ack; one-cycle response.
  - `ack_count` updates on that same edge.
- Queued re-assertion: `interrupt` is low for exactly `GAP_CYCLES` cycles, then high again.
- Back-to-back acks in consecutive cycles: the first is valid; the second lands in GAP or COUNT and is spurious.
- With `gen_en` = 1 at reset release, the first COUNT edge is the first edge after deassertion.

## Configuration

- `INT_GEN_PC_TRIGGER_EN` defined:
  - The first cycle in which `macroscopic_pc == TRIGGER_PC` (rising edge of the match, compared against the registered previous match) is an additional event.
  - The event is handled exactly like a timer event, in every state except IDLE.
  - A PC event coinciding with a timer event counts as one event.
- Not defined: `macroscopic_pc` is unused, the match register is absent, and behaviour is timer-only.

## Test plan

- Reset, `gen_en` = 1, `PERIOD` = 100, no acks -> `interrupt` rises 100 cycles after reset release and stays high. `pending` climbs to 15 and saturates there.
- Ack write (addr 0x7F20, byteen 4'b1111) 5 cycles after rise with `pending` = 0 -> `interrupt` low next edge, `ack_count` = 1. Next rise occurs at the next free-running timer event.
- `PERIOD` = 10, ack delayed 25 cycles -> `pending` = 2. The ack gives exactly 2 low cycles then re-assertion with `pending` = 1; a second ack repeats this with `pending` = 0.
- Ack to 0x7F24, and byteen = 0 at 0x7F20 -> `interrupt` stays high, `ack_count` unchanged. A byteen 4'b0001 write to 0x7F20 during COUNT -> `spurious_count` = 1.
- `reset` pulled low while `interrupt` = 1 and `pending` = 3 -> all outputs 0 immediately. `gen_en` = 0 mid-ASSERT -> `interrupt` low next edge, `pending` = 0.
- With `INT_GEN_PC_TRIGGER_EN`, `macroscopic_pc` = 0x3010 held 4 cycles during COUNT -> exactly one assertion next edge. A second match arriving during ASSERT -> `pending` = 1.

Source files
------------

// File: rtl/int_gen.sv
// Periodic level-interrupt source with acknowledge handshake, event queueing and ack/spurious counters.
// Optional PC-match event source enabled by defining INT_GEN_PC_TRIGGER_EN.
module int_gen #(
  parameter int unsigned PERIOD     = 100,
  parameter logic [31:0] ACK_ADDR   = 32'h0000_7F20,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [31:0] TRIGGER_PC = 32'h0000_3010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gen_en,
  input  logic [31:0] m_int_addr,
  input  logic [3:0]  m_int_byteen,
  input  logic [31:0] macroscopic_pc,
  output logic        interrupt,
  output logic [3:0]  pending,
  output logic [15:0] ack_count,
  output logic [7:0]  spurious_count
);

  // state  | meaning
  // IDLE   | generator off, timer held at reload, queue cleared
  // COUNT  | timer running, waiting for the next event
  // ASSERT | interrupt high, waiting for the acknowledge write
  // GAP    | forced low time before re-asserting a queued event
  typedef enum logic [1:0] {IDLE, COUNT, ASSERT, GAP} state_t;

  localparam int CW = $clog2(PERIOD);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(PERIOD - 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    pending_d, pend_inc;
  logic [15:0]   ack_count_d;
  logic [7:0]    spurious_d;
  logic          ack_hit, timer_evt, pc_evt, evt;

`ifdef INT_GEN_PC_TRIGGER_EN
  logic pc_match, pc_match_q;
  logic unused_addr;

  assign pc_match    = (macroscopic_pc == TRIGGER_PC);
  assign pc_evt      = pc_match & ~pc_match_q;
  assign unused_addr = ^m_int_addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_match_q <= 1'b0;
    else        pc_match_q <= pc_match;
  end
`else
  logic unused_pc;

  assign pc_evt    = 1'b0;
  assign unused_pc = ^{macroscopic_pc, TRIGGER_PC, m_int_addr[1:0]};
`endif

  assign ack_hit   = (m_int_byteen != 4'b0) && (m_int_addr[31:2] == ACK_ADDR[31:2]);
  assign timer_evt = (cnt_q == '0);
  // A PC match coinciding with the timer collapses into one event.
  assign evt       = (state_q != IDLE) && (timer_evt || pc_evt);
  assign pend_inc  = (pending == 4'hF) ? pending : pending + 4'd1;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    pending_d   = pending;
    ack_count_d = ack_count;
    spurious_d  = spurious_count;

    if (ack_hit) begin
      if (state_q == ASSERT)          ack_count_d = ack_count + 16'd1;
      else if (spurious_count != 8'hFF) spurious_d = spurious_count + 8'd1;
    end

    case (state_q)
      IDLE: begin
        pending_d = '0;
        if (gen_en) state_d = COUNT;
      end
      COUNT: begin
        if (evt) state_d = ASSERT;
      end
      ASSERT: begin
        if (evt) pending_d = pend_inc;
        if (ack_hit) begin
          state_d = (pending_d != 4'd0) ? GAP : COUNT;
          gap_d   = GAP_RELOAD;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = ASSERT;
          // An event on the exit cycle replaces the one being dequeued.
          if (!evt) pending_d = pending - 4'd1;
        end else begin
          gap_d = gap_q - 1'b1;
          if (evt) pending_d = pend_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!gen_en) begin
      state_d   = IDLE;
      pending_d = '0;
    end

    if (state_q == IDLE || !gen_en || cnt_q == '0) cnt_d = CNT_RELOAD;
    else                                           cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= CNT_RELOAD;
      gap_q          <= '0;
      pending        <= '0;
      interrupt      <= 1'b0;
      ack_count      <= '0;
      spurious_count <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      pending        <= pending_d;
      interrupt      <= (state_d == ASSERT);
      ack_count      <= ack_count_d;
      spurious_count <= spurious_d;
    end
  end

endmodule

// File: tb/tb_int_gen.sv
// Directed bench for int_gen: expected outputs are queued with each stimulus step and
// popped for comparison once the DUT has had the edge(s) to respond.
module tb_int_gen;

  localparam int unsigned P = 10;
  localparam int unsigned G = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gen_en;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic [31:0] macroscopic_pc;
  logic        interrupt;
  logic [3:0]  pending;
  logic [15:0] ack_count;
  logic [7:0]  spurious_count;

  typedef struct packed {
    logic        irq;
    logic [3:0]  pend;
    logic [15:0] ack;
    logic [7:0]  spur;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  int_gen #(
    .PERIOD(P),
    .ACK_ADDR(32'h0000_7F20),
    .GAP_CYCLES(G),
    .TRIGGER_PC(32'h0000_3010)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .gen_en(gen_en),
    .m_int_addr(m_int_addr),
    .m_int_byteen(m_int_byteen),
    .macroscopic_pc(macroscopic_pc),
    .interrupt(interrupt),
    .pending(pending),
    .ack_count(ack_count),
    .spurious_count(spurious_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic irq, input logic [3:0] pend,
                          input logic [15:0] ack, input logic [7:0] spur);
    exp_t e;
    e.irq  = irq;
    e.pend = pend;
    e.ack  = ack;
    e.spur = spur;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: no expected entry, got irq=%0b pend=%0d", interrupt, pending);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total += 4;
    assert (interrupt === e.irq) else begin
      bad++;
      $error("FAIL %s interrupt: got %0b want %0b", t, interrupt, e.irq);
    end
    assert (pending === e.pend) else begin
      bad++;
      $error("FAIL %s pending: got %0d want %0d", t, pending, e.pend);
    end
    assert (ack_count === e.ack) else begin
      bad++;
      $error("FAIL %s ack_count: got %0d want %0d", t, ack_count, e.ack);
    end
    assert (spurious_count === e.spur) else begin
      bad++;
      $error("FAIL %s spurious_count: got %0d want %0d", t, spurious_count, e.spur);
    end
  endtask

  // queue the expectation, advance n edges, then compare
  task automatic sc(input int n, input string tag, input logic irq, input logic [3:0] pend,
                    input logic [15:0] ack, input logic [7:0] spur);
    push_exp(tag, irq, pend, ack, spur);
    step(n);
    check_out();
  endtask

  task automatic drive_wr(input logic [31:0] addr, input logic [3:0] be);
    m_int_addr   = addr;
    m_int_byteen = be;
  endtask

  initial begin
    rst_n          = 1'b0;
    gen_en         = 1'b1;
    m_int_addr     = '0;
    m_int_byteen   = '0;
    macroscopic_pc = '0;

    sc(2, "reset_state", 1'b0, 4'd0, 16'd0, 8'd0);
    rst_n = 1'b1;

    // edge 1 enters COUNT; interrupt rises P edges later
    sc(10, "pre_rise", 1'b0, 4'd0, 16'd0, 8'd0);
    sc(1,  "first_rise", 1'b1, 4'd0, 16'd0, 8'd0);
    sc(9,  "hold_no_event", 1'b1, 4'd0, 16'd0, 8'd0);
    sc(1,  "queue_first", 1'b1, 4'd1, 16'd0, 8'd0);
    sc(130, "queue_14", 1'b1, 4'd14, 16'd0, 8'd0);
    sc(10, "queue_15", 1'b1, 4'd15, 16'd0, 8'd0);
    sc(20, "queue_saturate", 1'b1, 4'd15, 16'd0, 8'd0);

    push_exp("async_reset_full", 1'b0, 4'd0, 16'd0, 8'd0);
    rst_n = 1'b0;
    #2;
    check_out();
    step(1);
    rst_n = 1'b1;

    sc(10, "pre_rise_2", 1'b0, 4'd0, 16'd0, 8'd0);
    sc(1,  "rise_2", 1'b1, 4'd0, 16'd0, 8'd0);
    step(4);
    drive_wr(32'h0000_7F20, 4'b1111);
    sc(1, "ack_single", 1'b0, 4'd0, 16'd1, 8'd0);
    drive_wr('0, 4'b0);
    sc(4, "after_ack_low", 1'b0, 4'd0, 16'd1, 8'd0);
    sc(1, "free_run_rise", 1'b1, 4'd0, 16'd1, 8'd0);

    sc(24, "delayed_pend2", 1'b1, 4'd2, 16'd1, 8'd0);
    drive_wr(32'h0000_7F20, 4'b1111);
    sc(1, "ack_queued_a", 1'b0, 4'd2, 16'd2, 8'd0);
    drive_wr('0, 4'b0);
    sc(1, "gap_a", 1'b0, 4'd2, 16'd2, 8'd0);
    sc(1, "reassert_a", 1'b1, 4'd1, 16'd2, 8'd0);
    drive_wr(32'h0000_7F20, 4'b1111);
    sc(1, "ack_queued_b", 1'b0, 4'd1, 16'd3, 8'd0);
    drive_wr('0, 4'b0);
    sc(1, "gap_b", 1'b0, 4'd1, 16'd3, 8'd0);
    sc(1, "reassert_net_zero", 1'b1, 4'd1, 16'd3, 8'd0);
    sc(1, "hold_b", 1'b1, 4'd1, 16'd3, 8'd0);
    drive_wr(32'h0000_7F20, 4'b1111);
    sc(1, "ack_queued_c", 1'b0, 4'd1, 16'd4, 8'd0);
    drive_wr('0, 4'b0);
    sc(1, "gap_c", 1'b0, 4'd1, 16'd4, 8'd0);
    sc(1, "reassert_c", 1'b1, 4'd0, 16'd4, 8'd0);

    drive_wr(32'h0000_7F20, 4'b1111);
    sc(1, "b2b_valid", 1'b0, 4'd0, 16'd5, 8'd0);
    sc(1, "b2b_spurious", 1'b0, 4'd0, 16'd5, 8'd1);
    drive_wr('0, 4'b0);
    sc(3, "count_low", 1'b0, 4'd0, 16'd5, 8'd1);
    sc(1, "rise_3", 1'b1, 4'd0, 16'd5, 8'd1);
    drive_wr(32'h0000_7F24, 4'b1111);
    sc(1, "wrong_addr", 1'b1, 4'd0, 16'd5, 8'd1);
    drive_wr(32'h0000_7F20, 4'b0000);
    sc(1, "no_byteen", 1'b1, 4'd0, 16'd5, 8'd1);
    drive_wr(32'h0000_7F22, 4'b0100);
    sc(1, "ack_same_word", 1'b0, 4'd0, 16'd6, 8'd1);
    drive_wr(32'h0000_7F20, 4'b0001);
    sc(1, "spurious_count", 1'b0, 4'd0, 16'd6, 8'd2);
    drive_wr('0, 4'b0);

    sc(37, "pend3_before_dis", 1'b1, 4'd3, 16'd6, 8'd2);
    gen_en = 1'b0;
    sc(1, "disable_drop", 1'b0, 4'd0, 16'd6, 8'd2);
    sc(1, "idle_hold", 1'b0, 4'd0, 16'd6, 8'd2);
    gen_en = 1'b1;
    step(1);
    sc(9, "reenable_pre", 1'b0, 4'd0, 16'd6, 8'd2);
    sc(1, "reenable_rise", 1'b1, 4'd0, 16'd6, 8'd2);

    sc(31, "pend3_before_rst", 1'b1, 4'd3, 16'd6, 8'd2);
    push_exp("async_reset_pend3", 1'b0, 4'd0, 16'd0, 8'd0);
    rst_n = 1'b0;
    #2;
    check_out();
    step(1);
    rst_n = 1'b1;

`ifdef INT_GEN_PC_TRIGGER_EN
    sc(3, "pc_pre", 1'b0, 4'd0, 16'd0, 8'd0);
    macroscopic_pc = 32'h0000_3010;
    sc(1, "pc_trigger", 1'b1, 4'd0, 16'd0, 8'd0);
    sc(3, "pc_held_once", 1'b1, 4'd0, 16'd0, 8'd0);
    macroscopic_pc = '0;
    step(1);
    macroscopic_pc = 32'h0000_3010;
    sc(1, "pc_in_assert", 1'b1, 4'd1, 16'd0, 8'd0);
    macroscopic_pc = '0;
`else
    macroscopic_pc = 32'h0000_3010;
    sc(10, "pc_ignored", 1'b0, 4'd0, 16'd0, 8'd0);
    sc(1,  "timer_only_rise", 1'b1, 4'd0, 16'd0, 8'd0);
    macroscopic_pc = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
